// File: rtl/key_sel_ctrl_pkg.sv
// Shared definitions for the key-driven blocks: debounce FSM state encodings,
// the default debounce window and small elaboration-time helpers.
package key_sel_ctrl_pkg;

   localparam int DEF_CNT_MAX = 999_999;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILT_DN = 2'd1,
      ST_DOWN    = 2'd2,
      ST_FILT_UP = 2'd3
   } key_fsm_e;

   function automatic int cnt_width(input int cnt_max);
      return (cnt_max > 1) ? $clog2(cnt_max) : 1;
   endfunction

   // Level the raw key input shows while the button is not pressed.
   function automatic logic released_level(input int active_low);
      return (active_low != 0) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a synchronous
// active-high reset that loads a configurable idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_r;
   logic s2_r;

   // Synchronizer chain; reset loads the idle level so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= RST_VAL;
         s2_r <= RST_VAL;
      end else begin
         s1_r <= d;
         s2_r <= s1_r;
      end
   end

   assign q = s2_r;

endmodule

// File: rtl/key_sel_ctrl.sv
// Push-button debouncer that toggles the mux select once per qualified press
// and pulses key_flag for one cycle; key_state is the debounced level.
module key_sel_ctrl
   import key_sel_ctrl_pkg::*;
#(
   parameter int   CNT_MAX        = DEF_CNT_MAX,
   parameter int   KEY_ACTIVE_LOW = 1,
   parameter logic SEL_INIT       = 1'b0
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic sel,
   output logic key_flag,
   output logic key_state
);

   localparam int              CNT_W        = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic             RELEASED_LVL = released_level(KEY_ACTIVE_LOW);

   logic             key_sync_s;
   logic             raw_press_s;
   key_fsm_e         state_r;
   key_fsm_e         state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             sel_r;
   logic             sel_nxt_s;
   logic             flag_r;
   logic             flag_nxt_s;
   logic             level_r;
   logic             level_nxt_s;

   sync_2ff #(
      .RST_VAL (RELEASED_LVL)
   ) u_sync (
      .clk (sys_clk),
      .rst (sys_rst),
      .d   (key_in),
      .q   (key_sync_s)
   );

   assign raw_press_s = (KEY_ACTIVE_LOW != 0) ? ~key_sync_s : key_sync_s;

   // Next-state, counter and output decode; the counter restarts on every state change.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      sel_nxt_s   = sel_r;
      flag_nxt_s  = 1'b0;
      level_nxt_s = level_r;
      case (state_r)
         ST_IDLE: begin
            if (raw_press_s) begin
               state_nxt_s = ST_FILT_DN;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FILT_DN: begin
            if (!raw_press_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_DOWN;
               cnt_nxt_s   = CNT_ZERO;
               flag_nxt_s  = 1'b1;
               sel_nxt_s   = ~sel_r;
               level_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_DOWN: begin
            if (!raw_press_s) begin
               state_nxt_s = ST_FILT_UP;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_DOWN;
            end
         end
         ST_FILT_UP: begin
            // A press seen again during release filtering is the same press: no new flag.
            if (raw_press_s) begin
               state_nxt_s = ST_DOWN;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
               level_nxt_s = 1'b0;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            level_nxt_s = 1'b0;
         end
      endcase
   end

   // State, counter and output registers; reset has priority over filter completion.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         sel_r   <= SEL_INIT;
         flag_r  <= 1'b0;
         level_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         sel_r   <= sel_nxt_s;
         flag_r  <= flag_nxt_s;
         level_r <= level_nxt_s;
      end
   end

   assign sel       = sel_r;
   assign key_flag  = flag_r;
   assign key_state = level_r;

endmodule

// File: tb/tb_key_sel_ctrl.sv
// Self-checking bench for key_sel_ctrl (CNT_MAX=20, active-low key, SEL_INIT=0)
// with a behavioural mux2_1 on the select output.
module tb_key_sel_ctrl;

   localparam int CNT_MAX = 20;
   localparam int LAT     = CNT_MAX + 3;

   typedef struct {
      logic  key;
      int    cycles;
      bit    flag;
      logic  fin_state;
      logic  fin_sel;
      bit    chk_mux;
      string name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_in = 1'b1;
   logic       sel;
   logic       key_flag;
   logic       key_state;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'hFF;
   logic [7:0] mux_out;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   flag_q[$];
   logic exp_sel = 1'b0;
   logic exp_state = 1'b0;
   vec_t tbl[8];

   key_sel_ctrl #(
      .CNT_MAX        (CNT_MAX),
      .KEY_ACTIVE_LOW (1),
      .SEL_INIT       (1'b0)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .key_in    (key_in),
      .sel       (sel),
      .key_flag  (key_flag),
      .key_state (key_state)
   );

   assign mux_out = sel ? in_b : in_a;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Flag scoreboard: every edge after reset either pops an expected pulse or requires no pulse.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (flag_q.size() != 0 && flag_q[0] == cyc) begin
         void'(flag_q.pop_front());
         check("key_flag_pulse", {7'd0, key_flag}, 8'd1);
      end else if (cyc > 1) begin
         check("key_flag_quiet", {7'd0, key_flag}, 8'd0);
      end
   end

   // Called at a falling edge: drive the key, then check levels each cycle of the phase.
   task automatic apply_phase(input logic key, input int cycles, input bit flag,
                              input logic fin_state, input logic fin_sel, input string name);
      int start;
      int k;
      key_in = key;
      start  = cyc;
      if (flag) flag_q.push_back(start + LAT);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         k = cyc - start;
         check({name, "_state"}, {7'd0, key_state}, {7'd0, (k >= LAT) ? fin_state : exp_state});
         check({name, "_sel"},   {7'd0, sel},       {7'd0, (k >= LAT) ? fin_sel : exp_sel});
      end
      exp_state = fin_state;
      exp_sel   = fin_sel;
   endtask

   task automatic reset_pulse(input string name);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      exp_sel   = 1'b0;
      exp_state = 1'b0;
      check({name, "_sel"},   {7'd0, sel},       8'd0);
      check({name, "_state"}, {7'd0, key_state}, 8'd0);
      check({name, "_flag"},  {7'd0, key_flag},  8'd0);
   endtask

   task automatic run_row(input int idx);
      in_a = 8'($urandom_range(0, 255));
      in_b = ~in_a;
      apply_phase(tbl[idx].key, tbl[idx].cycles, tbl[idx].flag,
                  tbl[idx].fin_state, tbl[idx].fin_sel, tbl[idx].name);
      if (tbl[idx].chk_mux) check({tbl[idx].name, "_mux"}, mux_out, exp_sel ? in_b : in_a);
   endtask

   initial begin
      tbl[0] = '{1'b0, 40, 1'b1, 1'b1, 1'b1, 1'b0, "t2_press"};
      tbl[1] = '{1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b0, "t2_release"};
      tbl[2] = '{1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, "t4_short"};
      tbl[3] = '{1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b0, "t4_idle"};
      tbl[4] = '{1'b0, 40, 1'b1, 1'b1, 1'b1, 1'b1, "t5_press1"};
      tbl[5] = '{1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b1, "t5_release1"};
      tbl[6] = '{1'b0, 40, 1'b1, 1'b1, 1'b0, 1'b1, "t5_press2"};
      tbl[7] = '{1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b1, "t5_release2"};

      // Test 1: reset held for three edges, then idle with the key released.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_rst_sel",   {7'd0, sel},       8'd0);
         check("t1_rst_flag",  {7'd0, key_flag},  8'd0);
         check("t1_rst_state", {7'd0, key_state}, 8'd0);
      end
      rst = 1'b0;
      apply_phase(1'b1, 10, 1'b0, 1'b0, 1'b0, "t1_idle");

      // Test 2: clean press then clean release.
      for (int r = 0; r < 2; r++) run_row(r);

      // Test 3: bounce every 3 cycles, then settle pressed.
      for (int t = 0; t < 10; t++) begin
         apply_phase((t % 2 == 0) ? 1'b0 : 1'b1, 3, 1'b0, exp_state, exp_sel, "t3_bounce");
      end
      apply_phase(1'b0, 40, 1'b1, 1'b1, 1'b0, "t3_settle");
      apply_phase(1'b1, 40, 1'b0, 1'b0, 1'b0, "t3_release");

      // Tests 4 and 5: short press rejected; two full presses through the mux.
      for (int r = 2; r < 8; r++) run_row(r);

      // Set sel=1 so the resets below visibly restore SEL_INIT.
      apply_phase(1'b0, 40, 1'b1, 1'b1, 1'b1, "t6_prep_press");
      apply_phase(1'b1, 40, 1'b0, 1'b0, 1'b1, "t6_prep_release");

      // Test 6: reset with cnt=10 in FILT_DN while the key stays held.
      apply_phase(1'b0, 13, 1'b0, 1'b0, 1'b1, "t6_filter");
      reset_pulse("t6_rst");
      apply_phase(1'b0, 40, 1'b1, 1'b1, 1'b1, "t6_rehold");
      apply_phase(1'b1, 40, 1'b0, 1'b0, 1'b1, "t6_release");

      // Test 7: reset on the very edge the filter would complete.
      apply_phase(1'b0, 22, 1'b0, 1'b0, 1'b1, "t7_filter");
      reset_pulse("t7_rst");
      apply_phase(1'b0, 40, 1'b1, 1'b1, 1'b1, "t7_rehold");
      apply_phase(1'b1, 40, 1'b0, 1'b0, 1'b1, "t7_release");

      repeat (2) @(negedge clk);
      n_checks++;
      if (flag_q.size() != 0) begin
         n_fail++;
         $display("FAIL flag_queue_drained: got %0d pending expected 0", flag_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
